// File: rtl/mips_pkg.sv
// Shared constants, scoreboard entry layout and latency helper for the MIPS
// pipeline forwarding logic.
package mips_pkg;

  localparam int FWD_RF     = 0;
  localparam int FWD_EX_MEM = 1;
  localparam int FWD_MEM_WB = 2;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  localparam int MIPS_AW    = 5;
  localparam int MIPS_LW    = 2;
  localparam int MIPS_DEPTH = 3;

  typedef struct packed {
    logic               valid;
    logic [MIPS_AW-1:0] rd;
    logic [MIPS_LW-1:0] lat;
  } sb_entry_t;

  localparam int ENTRY_W = $bits(sb_entry_t);

  // A latency of 0 means "ALU-like"; anything past the last stage saturates.
  function automatic int clamp_lat(input int lat, input int max_lat);
    if (lat < LAT_ALU) return LAT_ALU;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/fwd_operand_match.sv
// Youngest-producer search and latency check for a single source operand.
// Purely combinational; one copy per operand.
module fwd_operand_match
  import mips_pkg::*;
#(
  parameter int AW     = MIPS_AW,
  parameter int DEPTH  = MIPS_DEPTH,
  parameter int LW     = MIPS_LW,
  parameter int SW     = $clog2(DEPTH),
  parameter int FWD_EN = 1
) (
  input  logic [AW-1:0]       src,
  input  logic                used,
  input  logic [DEPTH-1:0]    ent_valid,
  input  logic [DEPTH*AW-1:0] ent_rd,
  input  logic [DEPTH*LW-1:0] ent_lat,
  output logic [SW-1:0]       sel,
  output logic                stall_req
);

  logic          hit;
  int            hit_idx;
  logic [LW-1:0] hit_lat;

  // Scan oldest to youngest so the lowest index (youngest producer) wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    hit_lat = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_valid[k] && ent_rd[k*AW +: AW] == src) begin
        hit     = 1'b1;
        hit_idx = k;
        hit_lat = ent_lat[k*LW +: LW];
      end
    end
  end

  // A producer leaving the last stage writes the register file this cycle.
  always_comb begin
    sel       = SW'(FWD_RF);
    stall_req = 1'b0;
    if (used && src != '0 && hit && (hit_idx + 1) <= (DEPTH - 1)) begin
      if (FWD_EN != 0 && (hit_idx + 1) >= int'(hit_lat)) begin
        sel = SW'(hit_idx + 1);
      end else begin
        stall_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding / hazard unit: shift-register scoreboard of in-flight writes,
// combinational ID stall and registered per-operand forward selects for EX.
module fwd_scoreboard_unit
  import mips_pkg::*;
#(
  parameter int AW      = MIPS_AW,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = MIPS_DEPTH,
  parameter int LW      = MIPS_LW,
  parameter int SW      = $clog2(DEPTH),
  parameter int FWD_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic [AW-1:0]         id_rd,
  input  logic [LW-1:0]         id_lat,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  output logic                  stall,
  output logic [NUM_SRC*SW-1:0] ex_fwd_sel
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [LW-1:0] lat;
  } entry_t;

  entry_t [DEPTH-1:0]    ent;
  entry_t                e0_next;
  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH*AW-1:0]   ent_rd;
  logic [DEPTH*LW-1:0]   ent_lat;
  logic [NUM_SRC*SW-1:0] sel_next;
  logic [NUM_SRC-1:0]    op_stall;
  logic                  bubble;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign ent_valid[i]         = ent[i].valid;
    assign ent_rd[i*AW +: AW]   = ent[i].rd;
    assign ent_lat[i*LW +: LW]  = ent[i].lat;
  end

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_op
    fwd_operand_match #(
      .AW     (AW),
      .DEPTH  (DEPTH),
      .LW     (LW),
      .SW     (SW),
      .FWD_EN (FWD_EN)
    ) u_match (
      .src       (id_src[j*AW +: AW]),
      .used      (id_src_used[j]),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd),
      .ent_lat   (ent_lat),
      .sel       (sel_next[j*SW +: SW]),
      .stall_req (op_stall[j])
    );
  end

  assign stall  = id_valid & ~flush & (|op_stall);
  assign bubble = flush | stall | ~id_valid;

  // Writes to r0 are never real producers, so they enter as invalid.
  always_comb begin
    e0_next = '0;
    if (!bubble) begin
      e0_next.valid = id_reg_write && (id_rd != '0);
      e0_next.rd    = id_rd;
      e0_next.lat   = LW'(clamp_lat(int'(id_lat), DEPTH - 1));
    end
  end

  // The scoreboard advances with the pipeline; a freeze keeps everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent        <= '0;
      ex_fwd_sel <= '0;
    end else if (!hold) begin
      ent        <= {ent[DEPTH-2:0], e0_next};
      ex_fwd_sel <= bubble ? '0 : sel_next;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard bench: forwarding and non-forwarding instances driven in lockstep
// and compared against a queue-based model of in-flight writes.
module tb_fwd_scoreboard_unit;

  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int SW    = 2;

  logic           clk;
  logic           rst;
  logic           hold;
  logic           flush;
  logic           id_valid;
  logic           id_reg_write;
  logic [AW-1:0]  id_rd;
  logic [1:0]     id_lat;
  logic [2*AW-1:0] id_src;
  logic [1:0]     id_src_used;
  logic           stall_f;
  logic           stall_n;
  logic [2*SW-1:0] sel_f;
  logic [2*SW-1:0] sel_n;

  fwd_scoreboard_unit #(.FWD_EN(1)) dut_fwd (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_rd(id_rd), .id_lat(id_lat),
    .id_src(id_src), .id_src_used(id_src_used), .stall(stall_f),
    .ex_fwd_sel(sel_f)
  );

  fwd_scoreboard_unit #(.FWD_EN(0)) dut_nofwd (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_rd(id_rd), .id_lat(id_lat),
    .id_src(id_src), .id_src_used(id_src_used), .stall(stall_n),
    .ex_fwd_sel(sel_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit v;
    int rd;
    int lat;
  } rec_t;

  typedef struct {
    bit stall_f;
    int sel_f0;
    int sel_f1;
    bit stall_n;
    int sel_n0;
    int sel_n1;
  } exp_t;

  // pipe_x[k] is the instruction k stages past ID (0 = EX).
  rec_t pipe_f[$];
  rec_t pipe_n[$];
  int   last_f[2];
  int   last_n[2];
  exp_t exp_q[$];
  int   checks;
  int   errors;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rec_t r;
    r.v = 1'b0; r.rd = 0; r.lat = 0;
    pipe_f.delete();
    pipe_n.delete();
    for (int i = 0; i < DEPTH; i++) begin
      pipe_f.push_back(r);
      pipe_n.push_back(r);
    end
    last_f = '{0, 0};
    last_n = '{0, 0};
  endtask

  function automatic int model_lat(input int lat);
    if (lat == 0) return 1;
    if (lat > DEPTH - 1) return DEPTH - 1;
    return lat;
  endfunction

  function automatic void eval_op(input bit fwd_en, input int src, input bit used,
                                  output bit st, output int sel);
    rec_t p[$];
    if (fwd_en) p = pipe_f;
    else        p = pipe_n;
    st  = 1'b0;
    sel = 0;
    if (!used || src == 0) return;
    for (int k = 0; k < p.size(); k++) begin
      if (p[k].v && p[k].rd == src) begin
        if (k + 1 <= DEPTH - 1) begin
          if (fwd_en && (k + 1) >= p[k].lat) sel = k + 1;
          else                               st  = 1'b1;
        end
        return;
      end
    end
  endfunction

  task automatic model_step(input bit fwd_en, input bit v, input bit rw, input int rd,
                            input int lat, input int s0, input int s1,
                            input bit [1:0] used, input bit h, input bit fl,
                            output bit exp_stall, output int e0, output int e1);
    bit   st0, st1, bub;
    int   c0, c1;
    rec_t r;
    eval_op(fwd_en, s0, used[0], st0, c0);
    eval_op(fwd_en, s1, used[1], st1, c1);
    exp_stall = v && !fl && (st0 || st1);
    if (h) begin
      e0 = fwd_en ? last_f[0] : last_n[0];
      e1 = fwd_en ? last_f[1] : last_n[1];
    end else begin
      bub   = fl || exp_stall || !v;
      e0    = bub ? 0 : c0;
      e1    = bub ? 0 : c1;
      r.v   = !bub && rw && rd != 0;
      r.rd  = rd;
      r.lat = model_lat(lat);
      if (fwd_en) begin
        pipe_f.push_front(r);
        void'(pipe_f.pop_back());
        last_f = '{e0, e1};
      end else begin
        pipe_n.push_front(r);
        void'(pipe_n.pop_back());
        last_n = '{e0, e1};
      end
    end
  endtask

  // One ID-stage cycle: drive after the edge, push what both DUTs must show.
  task automatic apply_stimulus(input bit v, input bit rw, input int rd, input int lat,
                                input int s0, input int s1, input bit [1:0] used,
                                input bit h, input bit fl);
    exp_t e;
    @(posedge clk);
    #2;
    id_valid     = v;
    id_reg_write = rw;
    id_rd        = 5'(rd);
    id_lat       = 2'(lat);
    id_src       = {5'(s1), 5'(s0)};
    id_src_used  = used;
    hold         = h;
    flush        = fl;
    model_step(1'b1, v, rw, rd, lat, s0, s1, used, h, fl, e.stall_f, e.sel_f0, e.sel_f1);
    model_step(1'b0, v, rw, rd, lat, s0, s1, used, h, fl, e.stall_n, e.sel_n0, e.sel_n1);
    exp_q.push_back(e);
  endtask

  // Monitor: stall mid-cycle, forward selects just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check_output("stall_fwd", int'(stall_f), int'(e.stall_f));
        check_output("stall_nofwd", int'(stall_n), int'(e.stall_n));
        @(posedge clk);
        #1;
        check_output("sel_fwd_op0", int'(sel_f[1:0]), e.sel_f0);
        check_output("sel_fwd_op1", int'(sel_f[3:2]), e.sel_f1);
        check_output("sel_nofwd_op0", int'(sel_n[1:0]), e.sel_n0);
        check_output("sel_nofwd_op1", int'(sel_n[3:2]), e.sel_n1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0; id_reg_write = 1'b0;
    id_rd = '0; id_lat = '0; id_src = '0; id_src_used = '0;
    #3;
    check_output("reset_sel_fwd", int'(sel_f), 0);
    check_output("reset_sel_nofwd", int'(sel_n), 0);
    check_output("reset_stall", int'(stall_f | stall_n), 0);
    #9;
    rst = 1'b0;

    // ALU chain: add r3 then consumer of r3
    apply_stimulus(1, 1, 3, 1, 0, 0, 2'b00, 0, 0);
    apply_stimulus(1, 0, 0, 1, 3, 0, 2'b01, 0, 0);
    // load-use on r4, then two more consumers
    apply_stimulus(1, 1, 4, 2, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 1, 4, 0, 2'b01, 0, 0);
    // two producers of r5, both operands read r5; then r0 write/read
    apply_stimulus(1, 1, 5, 1, 0, 0, 2'b00, 0, 0);
    apply_stimulus(1, 1, 5, 1, 0, 0, 2'b00, 0, 0);
    apply_stimulus(1, 0, 0, 1, 5, 5, 2'b11, 0, 0);
    apply_stimulus(1, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0, 0, 2'b11, 0, 0);
    // flush of a load-use consumer
    apply_stimulus(1, 1, 7, 2, 0, 0, 2'b00, 0, 0);
    apply_stimulus(1, 0, 0, 1, 7, 0, 2'b01, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    // freeze with a live forward select
    apply_stimulus(1, 1, 8, 1, 0, 0, 2'b00, 0, 0);
    apply_stimulus(1, 0, 0, 1, 8, 0, 2'b01, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 9, 1, 8, 9, 2'b11, 1, 0);
    apply_stimulus(1, 0, 0, 1, 8, 0, 2'b01, 0, 0);
    // fill the scoreboard, then reset asynchronously mid-cycle
    apply_stimulus(1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
    apply_stimulus(1, 1, 2, 1, 0, 0, 2'b00, 0, 0);
    apply_stimulus(1, 1, 3, 2, 0, 0, 2'b00, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    id_valid = 1'b1; id_reg_write = 1'b0; id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
    hold = 1'b0; flush = 1'b0;
    #1;
    check_output("async_rst_sel_fwd", int'(sel_f), 0);
    check_output("async_rst_sel_nofwd", int'(sel_n), 0);
    check_output("async_rst_stall", int'(stall_f | stall_n), 0);
    model_reset();
    #3;
    rst = 1'b0;
    apply_stimulus(1, 0, 0, 1, 3, 0, 2'b01, 0, 0);

    // randomized traffic over a small register window to force hazards
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 99) < 85, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 4), $urandom_range(0, 3),
                     $urandom_range(0, 4), $urandom_range(0, 4),
                     2'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) check_output("drain_timeout", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
